n16_5_mult: RTL and testbench
=============================

N16_5_MULT -- requirements
Module: n16_5_mult

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-high.
REQ-002 The ports SHALL be, in order (name, direction, width, meaning):
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, a/b are sampled this cycle.
- a, input, 16, unsigned multiplicand.
- b, input, 16, unsigned multiplier.
- Y, output, 32, registered unsigned approximate product.
- out_valid, output, 1, Y holds a new result.
REQ-003 The block SHALL have no parameters; the approximation configuration SHALL be fixed as defined under Function.

Function
REQ-004 Decomposition: a SHALL be split into 2-bit digits a_i = a[2i+1:2i], and b into b_j = b[2j+1:2j], for i, j = 0..7.
REQ-005 Each digit pair (i,j) SHALL form a 2x2 sub-product P_ij weighted by 2^(2(i+j)).
REQ-006 Approximate region: sub-products with i+j < 5 (15 blocks) SHALL use the approximate 2x2 block.
- Its output is 3 bits, equal to a_i*b_j, except 3*3 which SHALL give 7 (binary 111) instead of 9.
REQ-007 Exact region: sub-products with i+j >= 5 (49 blocks) SHALL be exact 4-bit 2x2 products.
REQ-008 The approximate product SHALL be the exact unsigned sum of all 64 weighted P_ij, truncated to 32 bits.
- No overflow is possible, because the result is at most the exact product.
REQ-009 Resulting error: Y = a*b - sum over approximate blocks with a_i=b_j=3 of 2*2^(2(i+j)).
- Y SHALL never exceed a*b.
- Y SHALL equal a*b whenever no approximate block sees 3*3.
REQ-010 The multiply and adder tree SHALL be combinational from a/b up to the output register.
REQ-011 On each rising clk edge with in_valid=1, Y SHALL load the approximate product of the a and b present at that edge, and out_valid SHALL be 1 in the next cycle.
- Latency is exactly 1 cycle; throughput is 1 result per cycle.
REQ-012 On a rising edge with in_valid=0, Y SHALL hold its previous value and out_valid SHALL be 0 in the next cycle.
REQ-013 Back-to-back valid inputs SHALL each produce their own result on consecutive cycles, with no bubbles and no backpressure.
REQ-014 Operand 0 on either input SHALL yield Y=0.
REQ-015 The result SHALL be independent of operand order (symmetric: a*b == b*a for every a, b).

Reset
REQ-016 While rst=1, Y SHALL be 0 and out_valid SHALL be 0 immediately, without waiting for a clock edge.
REQ-017 Reset asserted mid-operation SHALL discard any in-flight result, so no out_valid is issued for it.
REQ-018 After rst deasserts, the first rising edge with in_valid=1 SHALL produce a result one cycle later.

Verification
REQ-019 a=3, b=3, in_valid=1 -> next cycle Y=7, out_valid=1 (block (0,0) approximated).
REQ-020 a=0xFFFF, b=0xFFFF -> Y=0xFFFDF38F (4294833039), i.e. the exact product 0xFFFE0001 minus 3186.
REQ-021 Region boundary:
- a=0x0300, b=0x0003 -> Y=1792 (i+j=4, approximated).
- a=0x0C00, b=0x0003 -> Y=9216 (i+j=5, exact).
REQ-022 a=0x1234, b=0x0000 -> Y=0.
- Swapped operands for any random pair SHALL give identical Y.
REQ-023 Stream of 3 valid pairs on consecutive cycles: (2,3), (3,2), (0xFFFF,1).
- Responses SHALL be 6, 6, 65535 on the next 3 cycles with out_valid high.
- Then in_valid=0 -> out_valid=0 and Y holds 65535.
REQ-024 Assert rst asynchronously between edges while out_valid=1.
- Y=0 and out_valid=0 SHALL hold immediately.
- After release, a=5, b=7 -> Y=35 one cycle later.
- Randomized compare against the REQ-009 reference model.

Source files
------------

// File: rtl/n16_5_mult.sv
// n16_5_mult: registered 16x16 unsigned approximate multiplier.
// Operands are split into 2-bit digits. Digit products whose combined
// weight is low (i+j < 5) use an approximate 2x2 block that returns 7
// for 3*3; every other digit product is exact. The weighted digit
// products are summed combinationally and captured in a single output
// register, giving 1-cycle latency at 1 result per cycle.

// 2x2 digit multiplier; APPROX selects the 3*3 -> 7 variant.
module n16_5_mult_2x2 #(
    parameter bit APPROX = 1'b0
) (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);
    logic [3:0] exact;

    assign exact = {2'b00, x} * {2'b00, y};

    // The approximate block fits in 3 bits by mapping 9 down to 7.
    always_comb begin
        p = exact;
        if (APPROX && x == 2'd3 && y == 2'd3)
            p = 4'd7;
    end
endmodule

module n16_5_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] Y,
    output logic        out_valid
);
    localparam int DIGITS    = 8;
    localparam int APPROX_LT = 5;

    // Digit-pair products, indexed [i][j] for a digit i, b digit j.
    logic [DIGITS-1:0][DIGITS-1:0][3:0] pp;
    logic [31:0]                        prod;

    for (genvar i = 0; i < DIGITS; i++) begin : g_a
        for (genvar j = 0; j < DIGITS; j++) begin : g_b
            n16_5_mult_2x2 #(
                .APPROX ((i + j) < APPROX_LT)
            ) u_pp (
                .x (a[2*i +: 2]),
                .y (b[2*j +: 2]),
                .p (pp[i][j])
            );
        end
    end

    // Weighted sum of all digit products; the approximation only ever
    // lowers the result, so 32 bits cannot overflow.
    always_comb begin
        prod = '0;
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = 0; j < DIGITS; j++) begin
                prod = prod + ({28'd0, pp[i][j]} << (2 * (i + j)));
            end
        end
    end

    // Output register: load on valid, hold otherwise; reset clears at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                Y <= prod;
        end
    end
endmodule

// File: tb/tb_n16_5_mult.sv
// Directed and randomized checks of n16_5_mult against a reference that
// starts from the exact product and subtracts the 3*3 error terms.
module tb_n16_5_mult;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] Y;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    n16_5_mult dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .Y         (Y),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
        logic [63:0] r;
        r = {48'd0, x} * {48'd0, y};
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (i + j < 5 && x[2*i +: 2] == 2'd3 && y[2*j +: 2] == 2'd3)
                    r = r - (64'd2 << (2 * (i + j)));
        return r[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present inputs on the falling edge, let one rising edge pass,
    // and return on the next falling edge ready to sample.
    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic v);
        a        = x;
        b        = y;
        in_valid = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        rst      = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        #1 rst = 1'b1;
        #1;
        check("reset_y", Y, 32'd0);
        check("reset_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        drive(16'd3, 16'd3, 1'b1);
        check("3x3_y", Y, 32'd7);
        check("3x3_vld", {31'd0, out_valid}, 32'd1);

        drive(16'hFFFF, 16'hFFFF, 1'b1);
        check("max_y", Y, 32'hFFFDF38F);

        drive(16'h0300, 16'h0003, 1'b1);
        check("bound_ij4", Y, 32'd1792);
        drive(16'h0C00, 16'h0003, 1'b1);
        check("bound_ij5", Y, 32'd9216);

        drive(16'h1234, 16'h0000, 1'b1);
        check("zero_b", Y, 32'd0);
        drive(16'h0000, 16'h1234, 1'b1);
        check("zero_a", Y, 32'd0);

        drive(16'd2, 16'd3, 1'b1);
        check("stream0_y", Y, 32'd6);
        check("stream0_vld", {31'd0, out_valid}, 32'd1);
        drive(16'd3, 16'd2, 1'b1);
        check("stream1_y", Y, 32'd6);
        check("stream1_vld", {31'd0, out_valid}, 32'd1);
        drive(16'hFFFF, 16'd1, 1'b1);
        check("stream2_y", Y, 32'd65535);
        check("stream2_vld", {31'd0, out_valid}, 32'd1);
        drive(16'h5555, 16'h7777, 1'b0);
        check("idle_vld", {31'd0, out_valid}, 32'd0);
        check("idle_hold", Y, 32'd65535);

        // Asynchronous reset between edges while a result is showing.
        drive(16'd100, 16'd200, 1'b1);
        check("pre_rst_vld", {31'd0, out_valid}, 32'd1);
        a = 16'd9;
        b = 16'd9;
        #2 rst = 1'b1;
        #1;
        check("async_rst_y", Y, 32'd0);
        check("async_rst_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(16'd0, 16'd0, 1'b0);
        check("post_rst_vld", {31'd0, out_valid}, 32'd0);
        drive(16'd5, 16'd7, 1'b1);
        check("post_rst_y", Y, 32'd35);
        check("post_rst_v", {31'd0, out_valid}, 32'd1);

        // Random pairs, biased toward 3-digits in the low half, plus swap.
        for (int k = 0; k < 24; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (k % 3 == 0) ra = ra | 16'h00FF;
            if (k % 2 == 0) rb = rb | 16'h03CF;
            drive(ra, rb, 1'b1);
            check("rand_ab", Y, model(ra, rb));
            drive(rb, ra, 1'b1);
            check("rand_ba", Y, model(ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
